// File: rtl/aes_core.sv
// AES-128 iterative core: encrypts in 11 steps, then decrypts back to the plaintext by step 22.
// Optional define AES_KEYSCHED_PORT_EN exposes the expanded key schedule as an output port.
module aes_core (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [127:0]  message,
  input  logic [127:0]  key,
  output logic [127:0]  cipher,
  output logic          enc_done,
  output logic          dec_done
`ifdef AES_KEYSCHED_PORT_EN
  ,
  output logic [1407:0] key_schedule
`endif
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as SubBytes requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int unsigned i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int unsigned n);
    logic [15:0] d;
    d = {b, b};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = ginv(a);
    return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] a);
    return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int unsigned n = 0; n < 16; n++)
      o[8*n +: 8] = inv ? isbox(s[8*n +: 8]) : sbox(s[8*n +: 8]);
    return o;
  endfunction

  // Byte n sits at row n%4, column n/4; forward rotates rows left, inverse right.
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int unsigned  src;
    for (int unsigned n = 0; n < 16; n++) begin
      src = inv ? ((n % 4) + 4 * (((n / 4) + 4 - (n % 4)) % 4))
                : ((n % 4) + 4 * (((n / 4) + (n % 4)) % 4));
      o[8*(15-n) +: 8] = s[8*(15-src) +: 8];
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [31:0]  coef;
    logic [7:0]   acc;
    coef = inv ? 32'h0e0b0d09 : 32'h02030101;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++) begin
        acc = '0;
        for (int unsigned k = 0; k < 4; k++)
          acc = acc ^ gmul(coef[8*(3 - (k + 4 - r) % 4) +: 8], s[8*(15 - (4*c + k)) +: 8]);
        o[8*(15 - (4*c + r)) +: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [1407:0] expand_key(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1407:0] ks_out;
    rcon = 8'h01;
    for (int unsigned i = 0; i < 4; i++) w[i] = k[32*(3-i) +: 32];
    for (int unsigned i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon, 24'h000000};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int unsigned i = 0; i < 44; i++) ks_out[32*(43-i) +: 32] = w[i];
    return ks_out;
  endfunction

  logic [1407:0] ks;
  logic [4:0]    cnt, next_cnt;
  logic [127:0]  state, next_state;
  logic [127:0]  rk, sb;
  logic [3:0]    rk_idx;

  always_comb ks = expand_key(key);

`ifdef AES_KEYSCHED_PORT_EN
  always_comb key_schedule = ks;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      state <= '0;
    end else begin
      cnt   <= next_cnt;
      state <= next_state;
    end
  end

  // Decryption steps 12..21 walk the round keys back down from rk9 to rk0.
  always_comb begin
    next_cnt   = cnt;
    next_state = state;
    rk_idx     = '0;
    if (cnt <= 5'd11)      rk_idx = (cnt >= 5'd10) ? 4'd10 : cnt[3:0];
    else if (cnt <= 5'd21) rk_idx = 4'(5'd21 - cnt);
    rk = ks[128*(10 - rk_idx) +: 128];
    sb = sub_bytes(state, cnt > 5'd11);
    if (cnt == 5'd0)       next_state = message ^ rk;
    else if (cnt <= 5'd9)  next_state = mix_columns(shift_rows(sb, 1'b0), 1'b0) ^ rk;
    else if (cnt == 5'd10) next_state = shift_rows(sb, 1'b0) ^ rk;
    else if (cnt == 5'd11) next_state = state ^ rk;
    else if (cnt <= 5'd20) next_state = mix_columns(shift_rows(sb, 1'b1) ^ rk, 1'b1);
    else if (cnt == 5'd21) next_state = shift_rows(sb, 1'b1) ^ rk;
    if (cnt < 5'd22) next_cnt = cnt + 5'd1;
  end

  always_comb begin
    cipher   = state;
    enc_done = (cnt == 5'd11);
    dec_done = (cnt == 5'd22);
  end

endmodule

// File: tb/tb_aes_core.sv
// Bench for aes_core: table-driven AES model predicts cipher/enc_done/dec_done every cycle,
// plus FIPS-197 literal vectors, mid-run reset and (with AES_KEYSCHED_PORT_EN) key schedule checks.
module tb_aes_core;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [127:0]  message;
  logic [127:0]  key;
  logic [127:0]  cipher;
  logic          enc_done;
  logic          dec_done;
`ifdef AES_KEYSCHED_PORT_EN
  logic [1407:0] key_schedule;
`endif

  int errors = 0;
  int checks = 0;
  int k;
  logic checking = 1'b0;

  logic [7:0]   sb_tab [256];
  logic [127:0] m_rk   [11];
  logic [127:0] trace  [23];

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] M1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] M2 = 128'h3243f6a8885a308d313198a2e0370734;

  always #5 clk = ~clk;

  aes_core dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .message  (message),
    .key      (key),
    .cipher   (cipher),
    .enc_done (enc_done),
    .dec_done (dec_done)
`ifdef AES_KEYSCHED_PORT_EN
    , .key_schedule (key_schedule)
`endif
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return b[7] ? ((b << 1) ^ 8'h1b) : (b << 1);
  endfunction

  // S-box from exp/log tables over generator 3, then the FIPS-197 affine map bit by bit.
  task automatic build_sbox();
    logic [7:0] exp_t [256];
    int         lg [256];
    logic [7:0] e, inv, s, c63;
    c63 = 8'h63;
    e = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = e;
      lg[e] = i;
      e = e ^ xt(e);
    end
    for (int a = 0; a < 256; a++) begin
      inv = (a == 0) ? 8'h00 : exp_t[(255 - lg[a]) % 255];
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c63[b];
      sb_tab[a] = s;
    end
  endtask

  function automatic logic [127:0] sr_sb(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(4*c+r) -: 8] = sb_tab[s[127-8*(4*((c+r)%4)+r) -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] mixc(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  // trace[n] = cipher after n edges. The inverse steps retrace the forward rounds,
  // so after edge 12+j the state equals ShiftRows(SubBytes(trace[10-j])).
  task automatic build_trace(input logic [127:0] msg, input logic [127:0] kk);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = kk[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    trace[0] = '0;
    trace[1] = msg ^ m_rk[0];
    for (int r = 1; r < 10; r++) trace[r+1] = mixc(sr_sb(trace[r])) ^ m_rk[r];
    trace[11] = sr_sb(trace[10]) ^ m_rk[10];
    for (int j = 0; j < 10; j++) trace[12+j] = sr_sb(trace[10-j]);
    trace[22] = msg;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     k <= 0;
    else if (k < 22) k <= k + 1;
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("cyc_cipher", cipher, trace[k]);
      chk("cyc_enc_done", {127'd0, enc_done}, {127'd0, k == 11});
      chk("cyc_dec_done", {127'd0, dec_done}, {127'd0, k == 22});
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [127:0] msg, input logic [127:0] kk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    message = msg;
    key = kk;
    build_trace(msg, kk);
    #1;
    chk("reset_cipher", cipher, '0);
    chk("reset_done", {126'd0, enc_done, dec_done}, '0);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    message = M1;
    key = K1;
    build_sbox();
    build_trace(M1, K1);
    chk("model_sbox_00", {120'd0, sb_tab[0]}, 128'h63);
    chk("model_sbox_53", {120'd0, sb_tab[8'h53]}, 128'hed);
    chk("model_ct1", trace[11], 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("model_rk10_k1", m_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    checking = 1'b1;

    start_run(M1, K1);
    edges(1);  chk("v1_edge1", cipher, 128'h00102030405060708090a0b0c0d0e0f0);
    edges(1);  chk("v1_edge2", cipher, 128'h89d810e8855ace682d1843d8cb128fe4);
    edges(9);  chk("v1_edge11", cipher, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("v1_enc_done", {127'd0, enc_done}, 128'd1);
    edges(11); chk("v1_edge22", cipher, M1);
    chk("v1_dec_done", {127'd0, dec_done}, 128'd1);
    edges(8);  chk("v1_edge30", cipher, M1);
    chk("v1_dec_hold", {127'd0, dec_done}, 128'd1);
`ifdef AES_KEYSCHED_PORT_EN
    chk("ks_rk10_k1", key_schedule[127:0], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    for (int r = 0; r < 11; r++) chk("ks_model_k1", key_schedule[128*(10-r) +: 128], m_rk[r]);
`endif

    start_run(M2, K2);
    edges(11); chk("v2_edge11", cipher, 128'h3925841d02dc09fbdc118597196a0b32);
`ifdef AES_KEYSCHED_PORT_EN
    chk("ks_rk10_k2", key_schedule[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`endif
    edges(11); chk("v2_edge22", cipher, M2);

    start_run('0, '0);
    edges(11); chk("v3_zero_ct", cipher, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
    edges(11); chk("v3_edge22", cipher, '0);

    // Reset asserted between edges 5 and 6, then a full restart.
    start_run(M1, K1);
    edges(5);
    chk("mid_edge5", cipher, trace[5]);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_async_cipher", cipher, '0);
    chk("mid_async_done", {126'd0, enc_done, dec_done}, '0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    edges(10); chk("mid_edge10_not_done", {127'd0, enc_done}, 128'd0);
    edges(1);  chk("mid_edge11", cipher, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("mid_enc_done", {127'd0, enc_done}, 128'd1);
    edges(11); chk("mid_edge22", cipher, M1);

    @(negedge clk);
    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_core.md
AES_CORE -- requirements
Module: aes_core

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: message  input  128  plaintext block, FIPS-197 byte order; byte 0 = bits [127:120].
REQ-004 SHALL have port: key  input  128  AES-128 cipher key, same byte order.
REQ-005 SHALL have port: cipher  output  128  current state register value, driven directly from the register.
REQ-006 SHALL have port: enc_done  output  1  high while step counter = 11 (cipher holds ciphertext).
REQ-007 SHALL have port: dec_done  output  1  high while step counter = 22 (cipher holds recovered plaintext).

Function
REQ-008 SHALL expand key combinationally into 11 round keys rk0..rk10 per FIPS-197 KeyExpansion: RotWord, SubWord, Rcon 01,02,04,08,10,20,40,80,1b,36.
REQ-009 SHALL hold a 5-bit step counter and a 128-bit state register; state bytes are column-major, with byte n in row n mod 4 and column n div 4.
REQ-010 SHALL implement SubBytes/InvSubBytes per FIPS-197, either as lookup tables or as GF(2^8) inverse plus affine map.
REQ-011 SHALL implement ShiftRows as a left rotation of row r by r bytes, and InvShiftRows as a right rotation by r bytes.
REQ-012 SHALL implement MixColumns and InvMixColumns over GF(2^8) with reduction polynomial x^8+x^4+x^3+x+1.
REQ-013 SHALL implement AddRoundKey as a 128-bit XOR.
REQ-014 SHALL execute one step per rising edge, by counter value:
 - 0: state <= message ^ rk0.
 - 1..9: state <= MixColumns(ShiftRows(SubBytes(state))) ^ rk[counter].
 - 10: state <= ShiftRows(SubBytes(state)) ^ rk10.
 - 11: state <= state ^ rk10.
 - 12..20: state <= InvMixColumns(InvShiftRows(InvSubBytes(state)) ^ rk[21-counter]).
 - 21: state <= InvShiftRows(InvSubBytes(state)) ^ rk0.
 - Counter increments on each edge at values 0..21.
REQ-015 SHALL freeze counter and state at counter = 22 until reset; there is no restart other than reset.
REQ-016 SHALL present the ciphertext on cipher after exactly 11 edges and the recovered plaintext after exactly 22 edges following reset release.
REQ-017 SHALL sample message only at the counter = 0 edge; key SHALL be used live every step and must be held stable for all 22 steps, otherwise the output is undefined.
REQ-018 SHALL derive enc_done and dec_done combinationally from the counter, with no additional latency.

Reset
REQ-019 SHALL, on rst_n low, immediately clear the counter, state, and cipher to 0; enc_done and dec_done SHALL then read 0.
REQ-020 SHALL, on reset assertion mid-run, abort the operation; after release, the sequence restarts from counter = 0.

Configuration
REQ-021 SHALL, when AES_KEYSCHED_PORT_EN is defined, add output key_schedule (1408 bits) carrying rk0..rk10, with rk0 at bits [1407:1280] and rk10 at bits [127:0]; when the macro is undefined, this port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-022 SHALL pass: key 000102030405060708090a0b0c0d0e0f, message 00112233445566778899aabbccddeeff, rst_n released -> after edge 1 cipher = 00102030405060708090a0b0c0d0e0f0; after edge 2 cipher = 89d810e8855ace682d1843d8cb128fe4.
REQ-023 SHALL pass: same stimulus -> after edge 11 cipher = 69c4e0d86a7b0430d8cdb78070b4c55a with enc_done=1; after edge 22 cipher = 00112233445566778899aabbccddeeff with dec_done=1, unchanged at edge 30.
REQ-024 SHALL pass: key 2b7e151628aed2a6abf7158809cf4f3c, message 3243f6a8885a308d313198a2e0370734 -> after edge 11 cipher = 3925841d02dc09fbdc118597196a0b32.
REQ-025 SHALL pass (AES_KEYSCHED_PORT_EN defined): key 000102...0f -> key_schedule[127:0] = 13111d7fe3944a17f307a78b4d2b30c5; key 2b7e...4f3c -> d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-026 SHALL pass: assert rst_n low between edges 5 and 6 -> cipher = 0 immediately without a clock edge; after release, ciphertext appears after 11 further edges.
